// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Fetch FSM states, IF/ID bundle layout and the bubble encoding.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_e;

  localparam logic [5:0]  OPC_NOP   = 6'b000000;
  localparam logic [31:0] NOP_INSTR = {26'd0, OPC_NOP};
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_next;
    logic        valid;
  } if_id_t;

  function automatic if_id_t if_id_bubble(
    input logic [31:0] nop
  );
    if_id_bubble = '{
      instr:   nop,
      pc_next: 32'd0,
      valid:   1'b0
    };
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds on freeze, otherwise
// loads a fetched word or a NOP bubble every cycle.
module if_id_reg
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc_next,
  output if_id_t      q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= if_id_bubble(NOP_WORD);
    end else if (!hold) begin
      if (load) begin
        q <= '{
          instr:   d_instr,
          pc_next: d_pc_next,
          valid:   1'b1
        };
      end else begin
        q <= if_id_bubble(NOP_WORD);
      end
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem
// handshake, kill of redirected fetches, IF/ID drive.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] PC_STEP   =
    if_fetch_unit_pkg::PC_STEP,
  parameter logic [31:0] NOP_INSTR =
    if_fetch_unit_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] PCOut,
  output logic        if_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_q;
  logic [31:0]  ld_instr;
  logic         kill_q, kill_d;
  logic         ld, cap, in_flight;
  if_id_t       ifid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      hold_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      if (cap) hold_q <= imem_rdata;
    end
  end

  // a request stays outstanding past this edge
  assign in_flight =
    (state_q == S_WAIT && !imem_rvalid) ||
    (state_q == S_REQ && imem_gnt);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    kill_d   = kill_q;
    ld       = 1'b0;
    cap      = 1'b0;
    ld_instr = imem_rdata;
    unique case (state_q)
      S_REQ: begin
        if (imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
          if (kill_q) begin
            kill_d = 1'b0;
          end else if (!freeze) begin
            ld = 1'b1;
          end else begin
            cap     = 1'b1;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!freeze) begin
          ld       = 1'b1;
          ld_instr = hold_q;
          state_d  = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
    if (ld) pc_d = pc_q + PC_STEP;
    if (branch_taken) begin
      pc_d    = branch_addr;
      ld      = 1'b0;
      cap     = 1'b0;
      kill_d  = in_flight;
      state_d = in_flight ? S_WAIT : S_REQ;
    end
  end

  if_id_reg #(
    .NOP_WORD (NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .hold      (freeze && !branch_taken),
    .load      (ld),
    .d_instr   (ld_instr),
    .d_pc_next (pc_q + PC_STEP),
    .q         (ifid)
  );

  assign imem_req    = rst && (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign instruction = ifid.instr;
  assign PCOut       = ifid.pc_next;
  assign if_valid    = ifid.valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: random memory latency,
// freeze and redirects against a word-stream reference model.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'd0;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instruction;
  logic [31:0] PCOut;
  logic        if_valid;

  logic        zero = 1'b0;
  logic [31:0] zaddr = 32'd0;
  logic        w_gnt = 1'b0;
  logic        w_rvalid = 1'b0;
  logic [31:0] w_rdata = 32'd0;
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_instr;
  logic [31:0] w_pco;
  logic        w_valid;

  if_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instruction  (instruction),
    .PCOut        (PCOut),
    .if_valid     (if_valid)
  );

  if_fetch_unit #(
    .RESET_PC (32'hFFFF_FFFC)
  ) u_w (
    .clk          (clk),
    .rst          (rst),
    .freeze       (zero),
    .branch_taken (zero),
    .branch_addr  (zaddr),
    .imem_req     (w_req),
    .imem_addr    (w_addr),
    .imem_gnt     (w_gnt),
    .imem_rvalid  (w_rvalid),
    .imem_rdata   (w_rdata),
    .instruction  (w_instr),
    .PCOut        (w_pco),
    .if_valid     (w_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          frz;
    bit          br;
    bit          gnt;
    bit          rv;
    logic [31:0] tgt;
    bit          zw;
  } rec_t;

  rec_t rec_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  bit          pend = 0;
  int          pcnt = 0;
  logic [31:0] paddr = 32'd0;
  bit          wfire = 0;
  logic [31:0] waddr = 32'd0;

  function automatic logic [31:0] memfn(
    input logic [31:0] a
  );
    return a * 32'h9E37_79B1 + 32'h1357_9BDF;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // memory models plus random control for one cycle
  task automatic drive(input bit zw, input int gp);
    rec_t r;
    if (pend && pcnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memfn(paddr);
      pend        = 0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (pend) pcnt--;
    end
    imem_gnt = zw ? 1'b1 :
      (int'($urandom_range(0, 99)) < gp);
    if (imem_req && imem_gnt) begin
      pend  = 1;
      paddr = imem_addr;
      pcnt  = zw ? 0 : int'($urandom_range(0, 2));
    end
    freeze = !zw &&
      ($urandom_range(0, 99) < 30);
    branch_taken = !zw &&
      ($urandom_range(0, 99) < 5);
    if ($urandom_range(0, 9) == 0)
      branch_addr = 32'hFFFF_FFF8;
    else
      branch_addr = 32'($urandom_range(0, 63)) << 2;
    w_rvalid = wfire;
    w_rdata  = memfn(waddr);
    w_gnt    = w_req;
    wfire    = w_req;
    waddr    = w_addr;
    r = '{frz: freeze, br: branch_taken,
          gnt: imem_req && imem_gnt,
          rv: imem_rvalid, tgt: branch_addr,
          zw: zw};
    rec_q.push_back(r);
  endtask

  initial begin : monitor
    logic [31:0] e_pc, e_ins, e_pco;
    bit          e_val, stale, have;
    int          outst, cyc, nd, wn;
    rec_t        r;
    e_pc = 0; e_ins = 0; e_pco = 0;
    e_val = 0; stale = 0; have = 0;
    outst = 0; cyc = 0; nd = 0; wn = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        e_pc = 0; e_ins = 0; e_pco = 0;
        e_val = 0; stale = 0; have = 0;
        outst = 0; cyc = 0; nd = 0; wn = 0;
        chk("rst_instr", instruction, 32'd0);
        chk("rst_pcout", PCOut, 32'd0);
        chk("rst_valid", if_valid, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_w_req", w_req, 0);
      end else if (rec_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL sb_empty: got 0 want 1 @%0t",
                 $time);
      end else begin
        r = rec_q.pop_front();
        cyc++;
        outst = outst + (r.gnt ? 1 : 0)
                      - (r.rv ? 1 : 0);
        if (r.br) begin
          e_pc  = r.tgt;
          stale = (outst > 0);
          have  = 0;
          e_ins = 0; e_pco = 0; e_val = 0;
        end else if (r.rv && stale) begin
          stale = 0;
          if (!r.frz) begin
            e_ins = 0; e_pco = 0; e_val = 0;
          end
        end else if (r.rv && r.frz) begin
          have = 1;
        end else if ((r.rv || have) && !r.frz) begin
          have  = 0;
          e_ins = memfn(e_pc);
          e_pco = e_pc + 32'd4;
          e_val = 1;
          e_pc  = e_pc + 32'd4;
          nd++;
          if (r.zw) chk("zw_cadence", cyc, 2 * nd);
        end else if (!r.frz) begin
          e_ins = 0; e_pco = 0; e_val = 0;
        end
        chk("instr", instruction, e_ins);
        chk("pcout", PCOut, e_pco);
        chk("valid", if_valid, e_val);
        chk("req", imem_req, outst == 0 && !have);
        if (outst == 0 && !have)
          chk("addr", imem_addr, e_pc);
        if (cyc == 1)
          chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        if (cyc == 2)
          chk("wrap_addr1", w_addr, 32'd0);
        if (w_valid) begin
          if (wn == 0) begin
            chk("wrap_pco0", w_pco, 32'd0);
            chk("wrap_ins0", w_instr,
                memfn(32'hFFFF_FFFC));
          end else if (wn == 1) begin
            chk("wrap_pco1", w_pco, 32'd4);
            chk("wrap_ins1", w_instr, memfn(32'd0));
          end
          wn++;
        end
      end
    end
  end

  initial begin : stim
    bit hit;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (40) begin
      @(negedge clk);
      drive(1, 100);
    end
    repeat (1500) begin
      @(negedge clk);
      drive(0, 60);
    end
    repeat (800) begin
      @(negedge clk);
      drive(0, 20);
    end
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (pend) hit = 1;
      else drive(0, 60);
    end
    if (!hit) begin
      n_vec++;
      n_bad++;
      $display("FAIL swait_timeout: got 0 want 1");
    end
    rst = 1'b0;
    pend = 0; wfire = 0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    freeze = 1'b0; branch_taken = 1'b0;
    w_gnt = 1'b0; w_rvalid = 1'b0;
    #1;
    chk("mid_rst_instr", instruction, 32'd0);
    chk("mid_rst_pcout", PCOut, 32'd0);
    chk("mid_rst_valid", if_valid, 0);
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_addr", imem_addr, 32'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (30) begin
      @(negedge clk);
      drive(1, 100);
    end
    repeat (300) begin
      @(negedge clk);
      drive(0, 60);
    end
    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
